// File: rtl/rv32_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module : rv32_alu_pkg
// Brief  : Shared widths, ALU op select and arbiter FSM state encodings.
// Rev    : 1.0
// ============================================================================
package rv32_alu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_sel_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RESPOND = 3'd3,
    ST_CLEAR   = 3'd4
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rv32_alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : rv32_alu_arbiter_if
// Brief  : Requester, response and ALU-side signal bundle of the arbiter.
// Rev    : 1.0
// ============================================================================
interface rv32_alu_arbiter_if;
  import rv32_alu_pkg::*;

  logic [1:0]             i_req_valid;
  logic [1:0]             o_req_ready;
  logic [1:0][DATA_W-1:0] i_req_op_one;
  logic [1:0][DATA_W-1:0] i_req_op_two;
  logic [1:0][1:0]        i_req_sel;

  logic [1:0]             o_rsp_valid;
  logic [1:0]             i_rsp_ready;
  logic [DATA_W-1:0]      o_rsp_result;
  logic                   o_rsp_carry;
  logic                   o_rsp_error;

  logic                   o_alu_en;
  logic                   o_alu_stall_reset;
  logic                   o_alu_rst;
  logic [DATA_W-1:0]      o_alu_operand_one;
  logic [DATA_W-1:0]      o_alu_operand_two;
  alu_sel_t               o_alu_sel;
  logic                   i_alu_data_valid;
  logic [DATA_W-1:0]      i_alu_result;
  logic                   i_alu_carry_out;

  logic [7:0]             o_timeout_count;

  modport slave (
    input  i_req_valid, i_req_op_one, i_req_op_two, i_req_sel, i_rsp_ready,
           i_alu_data_valid, i_alu_result, i_alu_carry_out,
    output o_req_ready, o_rsp_valid, o_rsp_result, o_rsp_carry, o_rsp_error,
           o_alu_en, o_alu_stall_reset, o_alu_rst, o_alu_operand_one,
           o_alu_operand_two, o_alu_sel, o_timeout_count
  );

  modport master (
    output i_req_valid, i_req_op_one, i_req_op_two, i_req_sel, i_rsp_ready,
           i_alu_data_valid, i_alu_result, i_alu_carry_out,
    input  o_req_ready, o_rsp_valid, o_rsp_result, o_rsp_carry, o_rsp_error,
           o_alu_en, o_alu_stall_reset, o_alu_rst, o_alu_operand_one,
           o_alu_operand_two, o_alu_sel, o_timeout_count
  );

endinterface
`default_nettype wire

// File: rtl/rv32_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module : rv32_rr_arbiter2
// Brief  : Two-request grant; the pointer holder wins a tie. One-hot or zero.
// Rev    : 1.0
// ============================================================================
module rv32_rr_arbiter2 (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic [1:0] o_grant
);

  logic w_other;

  assign w_other = ~i_ptr;

  always_comb begin
    o_grant = 2'b00;
    if (i_req[i_ptr]) begin
      o_grant[i_ptr] = 1'b1;
    end else if (i_req[w_other]) begin
      o_grant[w_other] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rv32_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rv32_alu_arbiter
// Brief  : Shares one multi-cycle ALU between two requesters, with timeout.
// Rev    : 1.0
// ============================================================================
module rv32_alu_arbiter #(
  parameter int TIMEOUT_CYCLES = 5
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  rv32_alu_arbiter_if.slave  bus
);
  import rv32_alu_pkg::*;

  localparam logic [7:0] c_TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] c_COUNT_MAX  = 8'hFF;

  arb_state_t        r_state;
  arb_state_t        w_next_state;
  logic              r_ptr;
  logic              r_owner;
  logic [DATA_W-1:0] r_op_one;
  logic [DATA_W-1:0] r_op_two;
  alu_sel_t          r_sel;
  logic [7:0]        r_timer;
  logic [DATA_W-1:0] r_result;
  logic              r_carry;
  logic              r_error;
  logic [7:0]        r_tcount;
  logic [1:0]        w_grant;
  logic              w_timed_out;

  rv32_rr_arbiter2 u_arb (
    .i_req   (bus.i_req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  assign w_timed_out = (r_timer == c_TIMER_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (|w_grant) w_next_state = ST_ISSUE;
      ST_ISSUE:   w_next_state = ST_WAIT;
      ST_WAIT:    if (bus.i_alu_data_valid || w_timed_out) w_next_state = ST_RESPOND;
      ST_RESPOND: if (bus.i_rsp_ready[r_owner]) w_next_state = ST_CLEAR;
      ST_CLEAR:   w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // Capture/latch datapath; a late data_valid on the last timer cycle still counts as success.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr    <= 1'b0;
      r_owner  <= 1'b0;
      r_op_one <= '0;
      r_op_two <= '0;
      r_sel    <= ALU_ADD;
      r_timer  <= 8'd0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_error  <= 1'b0;
      r_tcount <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_grant) begin
            r_owner  <= w_grant[1];
            r_op_one <= bus.i_req_op_one[w_grant[1]];
            r_op_two <= bus.i_req_op_two[w_grant[1]];
            r_sel    <= alu_sel_t'(bus.i_req_sel[w_grant[1]]);
          end
        end
        ST_ISSUE: r_timer <= 8'd0;
        ST_WAIT: begin
          if (bus.i_alu_data_valid) begin
            r_result <= bus.i_alu_result;
            r_carry  <= bus.i_alu_carry_out;
            r_error  <= 1'b0;
          end else if (w_timed_out) begin
            r_result <= '0;
            r_carry  <= 1'b0;
            r_error  <= 1'b1;
            if (r_tcount != c_COUNT_MAX) r_tcount <= r_tcount + 8'd1;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        ST_CLEAR: r_ptr <= ~r_owner;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.o_req_ready       = 2'b00;
    bus.o_rsp_valid       = 2'b00;
    bus.o_rsp_result      = '0;
    bus.o_rsp_carry       = 1'b0;
    bus.o_rsp_error       = 1'b0;
    bus.o_alu_en          = 1'b0;
    bus.o_alu_stall_reset = 1'b0;
    bus.o_alu_rst         = ~i_rst_n;
    bus.o_alu_operand_one = '0;
    bus.o_alu_operand_two = '0;
    bus.o_alu_sel         = ALU_ADD;
    case (r_state)
      ST_IDLE: begin
        if (i_rst_n) bus.o_req_ready = w_grant;
      end
      ST_ISSUE: begin
        bus.o_alu_en          = 1'b1;
        bus.o_alu_stall_reset = 1'b1;
        bus.o_alu_operand_one = r_op_one;
        bus.o_alu_operand_two = r_op_two;
        bus.o_alu_sel         = r_sel;
      end
      ST_WAIT: begin
        bus.o_alu_en          = 1'b1;
        bus.o_alu_operand_one = r_op_one;
        bus.o_alu_operand_two = r_op_two;
        bus.o_alu_sel         = r_sel;
      end
      ST_RESPOND: begin
        bus.o_rsp_valid[r_owner] = 1'b1;
        bus.o_rsp_result         = r_result;
        bus.o_rsp_carry          = r_carry;
        bus.o_rsp_error          = r_error;
      end
      ST_CLEAR: bus.o_alu_rst = 1'b1;
      default: ;
    endcase
  end

  assign bus.o_timeout_count = r_tcount;

endmodule
`default_nettype wire
